clock_period_meter: RTL

//  Downstream consumer of the ~12 MHz test/toggle clock produced by the clock-stimulus bench.

---
 rtl/cpm_pkg.sv | 24 ++
 rtl/cpm_sync_edge.sv | 47 ++++
 rtl/clock_period_meter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cpm_pkg.sv
// ----------------------------------------------------------------------------
// cpm_pkg
// Shared types and constants for the clock period meter.
//   state_e      : measurement FSM states
//   CNT_W_DFLT   : default counter width
//   CNT_MAX      : all-ones value at the default counter width
//   TIMEOUT_DFLT : default stall timeout in clk cycles
//   SYNC_N_DFLT  : default synchronizer depth
// ----------------------------------------------------------------------------
package cpm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    MEAS  = 2'd2,
    STALL = 2'd3
  } state_e;

  localparam int CNT_W_DFLT   = 16;
  localparam logic [CNT_W_DFLT-1:0] CNT_MAX = {CNT_W_DFLT{1'b1}};
  localparam int TIMEOUT_DFLT = 1000;
  localparam int SYNC_N_DFLT  = 2;

endpackage

// File: rtl/cpm_sync_edge.sv
// ----------------------------------------------------------------------------
// cpm_sync_edge
// Brings an asynchronous level into the clk domain through a SYNC_N-deep
// flop chain, then registers it once more so rising/falling edges can be
// detected as single-cycle pulses.
//   clk, rst_n : system clock, async active-low reset
//   sig_in     : asynchronous input level
//   rise       : one-cycle pulse on a synchronized 0->1 transition
//   fall       : one-cycle pulse on a synchronized 1->0 transition
// ----------------------------------------------------------------------------
module cpm_sync_edge
  import cpm_pkg::*;
#(
  parameter int SYNC_N = SYNC_N_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_N-1:0] sync_q, sync_d;
  logic              s_d_q, s_d_d;
  logic              s;

  assign s = sync_q[SYNC_N-1];

  always_comb begin
    sync_d = {sync_q[SYNC_N-2:0], sig_in};
    s_d_d  = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s_d_q  <= s_d_d;
    end
  end

  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

endmodule

// File: rtl/clock_period_meter.sv
// ----------------------------------------------------------------------------
// clock_period_meter
// Measures the period (rise to rise) and high time (rise to fall) of an
// asynchronous clock in clk cycles, tracks min/max period, flags a stalled
// input and presents each result through a valid/ready register.
//   clk, rst_n : system clock, async active-low reset
//   sig_in     : measured clock, asynchronous to clk
//   enable     : 1 = measure, 0 = drop back to IDLE
//   clear      : pulse; resets min/max/overrun
//   res_valid  : result register holds an unconsumed measurement
//   res_ready  : consumer accepts when res_valid && res_ready
//   period     : last captured rise-to-rise count
//   high_cnt   : rise-to-fall count of the same period (0 if no fall seen)
//   min_per    : smallest period since reset/clear (all-ones when none)
//   max_per    : largest period since reset/clear
//   stalled    : no rising edge for TIMEOUT cycles
//   overrun    : sticky; a pending result was overwritten
// ----------------------------------------------------------------------------
module clock_period_meter
  import cpm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DFLT,
  parameter int TIMEOUT = TIMEOUT_DFLT,
  parameter int SYNC_N  = SYNC_N_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  input  logic             clear,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] min_per,
  output logic [CNT_W-1:0] max_per,
  output logic             stalled,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] ONES      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

  logic rise, fall;

  cpm_sync_edge #(.SYNC_N(SYNC_N)) u_sync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             stalled_q, stalled_d;
  logic             cap;

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic             overrun_q, overrun_d;
  logic             ovw;

  // Saturating increment: a missing input must never wrap into a short period.
  assign cnt_inc = (cnt_q == ONES) ? cnt_q : cnt_q + ONE;

  // --------------------------------------------------------------------------
  // Measurement FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    stalled_d = stalled_q;
    cap       = 1'b0;

    if (!enable) begin
      // Leaving measurement discards the partial period; the result
      // register is deliberately untouched so a pending result survives.
      state_d   = IDLE;
      cnt_d     = '0;
      hi_d      = '0;
      stalled_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          hi_d    = '0;
          state_d = ARM;
        end
        ARM: begin
          // First edge only starts the count; no result for it.
          if (rise) begin
            cnt_d   = ONE;
            hi_d    = '0;
            state_d = MEAS;
          end
        end
        MEAS: begin
          cnt_d = cnt_inc;
          if (fall) hi_d = cnt_q;
          if (rise) begin
            cap   = 1'b1;
            cnt_d = ONE;
            hi_d  = '0;
          end else if (cnt_q == TIMEOUT_C) begin
            state_d   = STALL;
            stalled_d = 1'b1;
          end
        end
        STALL: begin
          // The stalled interval is not a valid period; restart cleanly.
          if (rise) begin
            stalled_d = 1'b0;
            cnt_d     = ONE;
            hi_d      = '0;
            state_d   = MEAS;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Result register, handshake and min/max tracking
  // --------------------------------------------------------------------------
  always_comb begin
    period_d = period_q;
    high_d   = high_q;
    valid_d  = valid_q;
    min_d    = min_q;
    max_d    = max_q;
    ovw      = 1'b0;

    if (cap) begin
      period_d = cnt_q;
      high_d   = hi_q;
      valid_d  = 1'b1;
      // Overwrite only counts as lost data if nobody takes the old result now.
      if (valid_q && !res_ready) ovw = 1'b1;
    end else if (valid_q && res_ready) begin
      valid_d = 1'b0;
    end

    if (cap) begin
      if (clear) begin
        // A capture coinciding with clear seeds both trackers.
        min_d = cnt_q;
        max_d = cnt_q;
      end else begin
        min_d = (cnt_q < min_q) ? cnt_q : min_q;
        max_d = (cnt_q > max_q) ? cnt_q : max_q;
      end
    end else if (clear) begin
      min_d = ONES;
      max_d = '0;
    end

    overrun_d = clear ? 1'b0 : (overrun_q | ovw);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      stalled_q <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      min_q     <= ONES;
      max_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      stalled_q <= stalled_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      min_q     <= min_d;
      max_q     <= max_d;
      overrun_q <= overrun_d;
    end
  end

  assign res_valid = valid_q;
  assign period    = period_q;
  assign high_cnt  = high_q;
  assign min_per   = min_q;
  assign max_per   = max_q;
  assign stalled   = stalled_q;
  assign overrun   = overrun_q;

endmodule
